// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM states and sizing helper for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned mdu_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module mdu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        shifted   = {rem, quot[WIDTH-1]};
        fits      = (shifted >= {1'b0, divisor});
        // When the subtraction is taken the true difference is below divisor, so WIDTH bits suffice.
        diff      = shifted[WIDTH-1:0] - divisor;
        rem_next  = fits ? diff : shifted[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Define MDU_DIV_EN to build the divide datapath; otherwise DIV/DIVU are accepted as no-ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = mdu_clog2(WIDTH);

    mdu_state_t       state, state_next;
    mdu_op_t          op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, opnd, acc_lo;
    logic [WIDTH:0]   acc_hi;
    logic             neg_res;

    logic             is_mult_op, is_div_op, issue, last_step;
    logic             is_mul_q, sgn_q;
    logic [WIDTH:0]   mul_sum, step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;
`ifdef MDU_DIV_EN
    logic             neg_rem;
    logic [WIDTH-1:0] div_rem, div_quot, quot_fix, rem_fix;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? ('0 - x) : x;
    endfunction

    always_comb begin
        is_mult_op = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_DIV_EN
        is_div_op  = (op == MDU_DIV) || (op == MDU_DIVU);
`else
        is_div_op  = 1'b0;
`endif
        issue      = start && !flush && (is_mult_op || is_div_op);
        last_step  = (cnt == CW'(WIDTH - 1));
        is_mul_q   = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
        sgn_q      = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (issue) state_next = ST_PREP;
                ST_PREP: state_next = ST_RUN;
                ST_RUN:  if (last_step) state_next = ST_FIX;
                ST_FIX:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef MDU_DIV_EN
    mdu_divstep #(
        .WIDTH(WIDTH)
    ) u_divstep (
        .rem      (acc_hi[WIDTH-1:0]),
        .quot     (acc_lo),
        .divisor  (opnd),
        .rem_next (div_rem),
        .quot_next(div_quot)
    );
`endif

    // Multiply: the multiplier magnitude sits in acc_lo and retires LSB-first
    // while product bits shift in from the accumulator above it.
    always_comb begin
        mul_sum = acc_lo[0] ? (acc_hi + {1'b0, opnd}) : acc_hi;
        step_hi = {1'b0, mul_sum[WIDTH:1]};
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (!is_mul_q) begin
            step_hi = {1'b0, div_rem};
            step_lo = div_quot;
        end
`endif
    end

    always_comb begin
        prod_raw = {acc_hi[WIDTH-1:0], acc_lo};
        prod     = neg_res ? ('0 - prod_raw) : prod_raw;
        fix_hi   = prod[2*WIDTH-1:WIDTH];
        fix_lo   = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        quot_fix = neg_res ? ('0 - acc_lo) : acc_lo;
        rem_fix  = neg_rem ? ('0 - acc_hi[WIDTH-1:0]) : acc_hi[WIDTH-1:0];
        if (!is_mul_q) begin
            // Divide by zero reports the raw dividend, not the magnitude the iteration produced.
            if (b_q == '0) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
`ifdef MDU_DIV_EN
            neg_rem <= 1'b0;
`endif
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    ST_IDLE: begin
                        if (issue) begin
                            op_q <= mdu_op_t'(op);
                            a_q  <= src_a;
                            b_q  <= src_b;
                        end else if (start && op == MDU_MTHI) begin
                            hi <= src_a;
                        end else if (start && op == MDU_MTLO) begin
                            lo <= src_a;
                        end
                    end
                    ST_PREP: begin
                        if (is_mul_q) begin
                            opnd   <= mag(a_q, sgn_q);
                            acc_lo <= mag(b_q, sgn_q);
                        end else begin
                            opnd   <= mag(b_q, sgn_q);
                            acc_lo <= mag(a_q, sgn_q);
                        end
                        acc_hi  <= '0;
                        cnt     <= '0;
                        neg_res <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MDU_DIV_EN
                        neg_rem <= sgn_q & a_q[WIDTH-1];
`endif
                    end
                    ST_RUN: begin
                        cnt    <= cnt + CW'(1);
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                    end
                    ST_FIX: begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model plus directed literal cases.
// Honours MDU_DIV_EN the same way the design does.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .src_a(src_a),
        .src_b(src_b),
        .flush(flush),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit op_accepted(input logic [2:0] o);
`ifdef MDU_DIV_EN
        return o <= 3'd3;
`else
        return o <= 3'd1;
`endif
    endfunction

    // Returns {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0] pu;
        int sa, sb, q, r;
        logic [31:0] qv, rv;
        case (o)
            3'd0: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps;
            end
            3'd1: begin
                pu = {32'b0, a} * {32'b0, b};
                return pu;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q = sa / sb;
                r = sa % sb;
                qv = q;
                rv = r;
                return {rv, qv};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_done = 1'b0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_rem = 0;
            end else if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi   = m_pend[63:32];
                    m_lo   = m_pend[31:0];
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (op_accepted(op)) begin
                    m_pend = model_res(op, src_a, src_b);
                    m_rem  = LAT;
                end else if (op == 3'd4) begin
                    m_hi = src_a;
                end else if (op == 3'd5) begin
                    m_lo = src_a;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
        check("cmp_done", {31'b0, done}, {31'b0, m_done});
        check("cmp_hi", hi, m_hi);
        check("cmp_lo", lo, m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit seen);
        bc = 0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [63:0] mr;
        int bc;
        bit seen;
        mr = model_res(o, a, b);
        check({nm, "_model_hi"}, mr[63:32], eh);
        check({nm, "_model_lo"}, mr[31:0], el);
        issue(o, a, b);
        wait_done(bc, seen);
        check({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({nm, "_busy_cycles"}, bc, LAT);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        bit seen;
        int ndone;
        logic [2:0] o;
        logic [31:0] a, b;

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
`ifdef MDU_DIV_EN
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", MDU_DIVU, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_off_busy", {31'b0, busy}, 32'd0);
        check("div_off_hi", hi, 32'h0000_0001);
        check("div_off_lo", lo, 32'hFFFF_FFFE);
`endif

        issue(MDU_MTHI, 32'h0000_1234, 32'd0);
        issue(MDU_MTLO, 32'h0000_1234, 32'd0);
        issue(MDU_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush_no_done", ndone, 0);
        check("flush_hi", hi, 32'h0000_1234);
        check("flush_lo", lo, 32'h0000_1234);

        issue(MDU_MULTU, 32'd5, 32'd7);
        repeat (5) @(negedge clk);
        issue(MDU_MULT, 32'd100, 32'd100);
        wait_done(bc, seen);
        check("second_done_seen", {31'b0, seen}, 32'd1);
        check("second_hi", hi, 32'd0);
        check("second_lo", lo, 32'd35);
        @(negedge clk);
        check("second_not_restarted", {31'b0, busy}, 32'd0);

        @(negedge clk);
        start = 1'b1;
        op    = MDU_MTHI;
        src_a = 32'hCAFE_0000;
        @(negedge clk);
        check("mthi_hi", hi, 32'hCAFE_0000);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_done", {31'b0, done}, 32'd0);
        op    = MDU_MTLO;
        src_a = 32'h0000_BEEF;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h0000_BEEF);
        check("mtlo_hi", hi, 32'hCAFE_0000);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        check("mtlo_done", {31'b0, done}, 32'd0);

`ifdef MDU_DIV_EN
        issue(MDU_DIV, 32'd1000, 32'd7);
`else
        issue(MDU_MULT, 32'd1000, 32'd7);
`endif
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul3x4", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

        for (int it = 0; it < 40; it++) begin
            o = 3'($urandom_range(0, 6));
            a = pick();
            b = pick();
            issue(o, a, b);
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 99) == 0) flush = 1'b1;
                if ($urandom_range(0, 49) == 0) begin
                    start = 1'b1;
                    op    = 3'($urandom_range(0, 5));
                    src_a = $urandom;
                    src_b = pick();
                end
                @(negedge clk);
                flush = 1'b0;
                start = 1'b0;
                if (!busy) break;
            end
        end
        for (int n = 0; n < 60 && busy; n++) @(negedge clk);
        check("drain_idle", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
